// File: rtl/plane_block_packer.sv
// Packs 8-bit pixel bytes (MSB first) into 256-bit blocks with a block index within a plane.
// Optional PLANE_PACK_CSUM_EN adds csum[7:0], the running XOR of the bytes of the current plane.
module plane_block_packer #(
    parameter int BYTES_PER_BLOCK  = 32,
    parameter int BLOCKS_PER_PLANE = 256,
    parameter int IDX_W            = 8,
    localparam int BLOCK_W         = 8 * BYTES_PER_BLOCK
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         in_data,
    input  logic               in_valid,
    input  logic               in_sof,
    output logic               in_ready,
    output logic [BLOCK_W-1:0] blk_data,
    output logic               blk_valid,
    input  logic               blk_ready,
    output logic [IDX_W-1:0]   blk_idx,
    output logic               blk_last,
    output logic               plane_done,
`ifdef PLANE_PACK_CSUM_EN
    output logic [7:0]         csum,
`endif
    output logic               sync_err
);

    localparam int CNT_W = (BYTES_PER_BLOCK > 1) ? $clog2(BYTES_PER_BLOCK) : 1;
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BYTES_PER_BLOCK - 1);
    localparam logic [IDX_W-1:0] LAST_BLK  = IDX_W'(BLOCKS_PER_PLANE - 1);

    typedef enum logic {EMPTY, HOLD} state_t;

    state_t             state_q, state_d;
    logic [BLOCK_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               acc_full_q, acc_full_d;
    logic [IDX_W-1:0]   full_idx_q, full_idx_d;
    logic [IDX_W-1:0]   fill_idx_q, fill_idx_d;
    logic [BLOCK_W-1:0] out_q, out_d;
    logic [IDX_W-1:0]   out_idx_q, out_idx_d;
    logic               sync_err_q, sync_err_d;
    logic               plane_done_q, plane_done_d;

    logic               byte_acc, blk_hs, out_take, at_bound, resync, blk_done;
    logic               load_full, load_new;
    logic [CNT_W-1:0]   eff_cnt;
    logic [IDX_W-1:0]   eff_idx;
    logic [BLOCK_W-1:0] shifted;

    always_comb begin
        byte_acc  = in_valid && in_ready;
        blk_hs    = blk_valid && blk_ready;
        out_take  = (state_q == EMPTY) || blk_ready;
        at_bound  = (cnt_q == '0) && (fill_idx_q == '0);
        resync    = byte_acc && in_sof && !at_bound;
        eff_cnt   = resync ? '0 : cnt_q;
        eff_idx   = resync ? '0 : fill_idx_q;
        blk_done  = byte_acc && (eff_cnt == LAST_BYTE);
        // Old bits of a discarded/transferred block simply shift out over the next block.
        shifted   = {acc_q[BLOCK_W-9:0], in_data};
        load_full = acc_full_q && out_take;
        load_new  = blk_done && out_take;
    end

    always_comb begin
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        acc_full_d   = acc_full_q;
        full_idx_d   = full_idx_q;
        fill_idx_d   = fill_idx_q;
        out_d        = out_q;
        out_idx_d    = out_idx_q;
        sync_err_d   = sync_err_q | resync;
        plane_done_d = blk_hs && blk_last;
        if (load_full) begin
            acc_full_d = 1'b0;
            out_d      = acc_q;
            out_idx_d  = full_idx_q;
        end
        if (byte_acc) begin
            acc_d      = shifted;
            fill_idx_d = eff_idx;
            if (blk_done) begin
                cnt_d      = '0;
                fill_idx_d = (eff_idx == LAST_BLK) ? '0 : eff_idx + IDX_W'(1);
                if (load_new) begin
                    out_d     = shifted;
                    out_idx_d = eff_idx;
                end else begin
                    acc_full_d = 1'b1;
                    full_idx_d = eff_idx;
                end
            end else begin
                cnt_d = eff_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q        <= '0;
            cnt_q        <= '0;
            acc_full_q   <= 1'b0;
            full_idx_q   <= '0;
            fill_idx_q   <= '0;
            out_q        <= '0;
            out_idx_q    <= '0;
            sync_err_q   <= 1'b0;
            plane_done_q <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            acc_full_q   <= acc_full_d;
            full_idx_q   <= full_idx_d;
            fill_idx_q   <= fill_idx_d;
            out_q        <= out_d;
            out_idx_q    <= out_idx_d;
            sync_err_q   <= sync_err_d;
            plane_done_q <= plane_done_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= EMPTY;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: if (load_new || load_full) state_d = HOLD;
            HOLD:  if (blk_ready && !(load_new || load_full)) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    always_comb begin
        blk_valid  = (state_q == HOLD);
        // Only a completed block waiting behind an unaccepted output block stalls input.
        in_ready   = !(acc_full_q && (state_q == HOLD) && !blk_ready);
        blk_data   = out_q;
        blk_idx    = out_idx_q;
        blk_last   = (state_q == HOLD) && (out_idx_q == LAST_BLK);
        plane_done = plane_done_q;
        sync_err   = sync_err_q;
    end

`ifdef PLANE_PACK_CSUM_EN
    logic [7:0] csum_q, csum_d;

    always_comb begin
        csum_d = csum_q;
        if (byte_acc) csum_d = (at_bound || resync) ? in_data : (csum_q ^ in_data);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) csum_q <= '0;
        else     csum_q <= csum_d;
    end

    assign csum = csum_q;
`endif

endmodule

// File: tb/tb_plane_block_packer.sv
// Directed bench for plane_block_packer: latency, backpressure, resync, async reset, full plane.
module tb_plane_block_packer;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [7:0]   in_data = '0;
    logic         in_valid = 1'b0;
    logic         in_sof = 1'b0;
    logic         in_ready;
    logic [255:0] blk_data;
    logic         blk_valid;
    logic         blk_ready = 1'b0;
    logic [7:0]   blk_idx;
    logic         blk_last;
    logic         plane_done;
    logic         sync_err;
`ifdef PLANE_PACK_CSUM_EN
    logic [7:0]   csum;
`endif

    plane_block_packer dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_sof(in_sof), .in_ready(in_ready),
        .blk_data(blk_data), .blk_valid(blk_valid), .blk_ready(blk_ready),
        .blk_idx(blk_idx), .blk_last(blk_last), .plane_done(plane_done),
`ifdef PLANE_PACK_CSUM_EN
        .csum(csum),
`endif
        .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    bit mon_en = 1'b0;
    int exp_idx = 0;
    int nblk = 0;
    int npd = 0;
    logic [255:0] exp_blk, exp_blk2;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (mon_en) begin
            if (blk_valid && blk_ready) begin
                chk("plane_idx", blk_idx, exp_idx[7:0]);
                chk("plane_last", blk_last, exp_idx == 255);
                if (nblk == 0) chk("plane_blk0", blk_data, {32{8'h5A}});
                exp_idx = (exp_idx + 1) % 256;
                nblk++;
            end
            if (plane_done) begin
                npd++;
`ifdef PLANE_PACK_CSUM_EN
                chk("csum", csum, 8'hA5);
`endif
            end
        end
    endtask

    task automatic put(input logic [7:0] d, input logic s);
        in_valid = 1'b1;
        in_data  = d;
        in_sof   = s;
        tick();
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    initial begin
        #2;
        chk("rst_valid", blk_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_data", blk_data, 0);
        chk("rst_idx", blk_idx, 0);
        chk("rst_last", blk_last, 0);
        chk("rst_plane_done", plane_done, 0);
        chk("rst_sync_err", sync_err, 0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;

        // One block, 0x00..0x1F, downstream always ready
        blk_ready = 1'b1;
        exp_blk = '0;
        for (int i = 0; i < 32; i++) begin
            in_valid = 1'b1;
            in_data  = i[7:0];
            in_sof   = (i == 0);
            exp_blk  = {exp_blk[247:0], i[7:0]};
            chk("t1_in_ready", in_ready, 1);
            if (i == 31) chk("t1_not_early", blk_valid, 0);
            tick();
        end
        in_valid = 1'b0; in_sof = 1'b0;
        chk("t1_valid", blk_valid, 1);
        chk("t1_data", blk_data, 256'h000102030405060708090A0B0C0D0E0F101112131415161718191A1B1C1D1E1F);
        chk("t1_idx", blk_idx, 0);
        chk("t1_last", blk_last, 0);
        tick();
        chk("t1_drained", blk_valid, 0);

        // Backpressure: two blocks behind a stalled consumer
        blk_ready = 1'b0;
        exp_blk = '0; exp_blk2 = '0;
        for (int i = 0; i < 64; i++) begin
            logic [7:0] b;
            b = 8'h40 + i[7:0];
            if (i < 32) exp_blk = {exp_blk[247:0], b};
            else        exp_blk2 = {exp_blk2[247:0], b};
            in_valid = 1'b1;
            in_data  = b;
            chk("t2_in_ready_hi", in_ready, 1);
            tick();
        end
        in_valid = 1'b0;
        chk("t2_in_ready_low", in_ready, 0);
        chk("t2_valid", blk_valid, 1);
        chk("t2_data1", blk_data, exp_blk);
        chk("t2_idx1", blk_idx, 1);
        tick(); tick();
        chk("t2_hold_data", blk_data, exp_blk);
        chk("t2_hold_idx", blk_idx, 1);
        chk("t2_hold_in_ready", in_ready, 0);
        blk_ready = 1'b1;
        #1;
        chk("t2_ready_comb", in_ready, 1);
        tick();
        chk("t2_valid2", blk_valid, 1);
        chk("t2_data2", blk_data, exp_blk2);
        chk("t2_idx2", blk_idx, 2);
        tick();
        chk("t2_drained", blk_valid, 0);

        // in_sof on byte 10 of block 3
        for (int i = 0; i < 10; i++) put(8'h10 + i[7:0], 1'b0);
        chk("t3_no_err_yet", sync_err, 0);
        put(8'hC0, 1'b1);
        chk("t3_sync_err", sync_err, 1);
        exp_blk = 256'hC0;
        for (int i = 1; i < 32; i++) begin
            put(8'hC0 + i[7:0], 1'b0);
            exp_blk = {exp_blk[247:0], 8'hC0 + i[7:0]};
        end
        chk("t3_valid", blk_valid, 1);
        chk("t3_data", blk_data, exp_blk);
        chk("t3_idx", blk_idx, 0);
        tick();

        // Async reset with a pending block and 17 buffered bytes
        blk_ready = 1'b0;
        for (int i = 0; i < 49; i++) put(i[7:0], 1'b0);
        chk("t5_pending", blk_valid, 1);
        rst = 1'b1;
        #1;
        chk("t5_valid", blk_valid, 0);
        chk("t5_in_ready", in_ready, 1);
        chk("t5_sync_err", sync_err, 0);
        chk("t5_data", blk_data, 0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;

        // Full plane: 8192 bytes, one 0xFF among 0x5A
        blk_ready = 1'b1;
        mon_en = 1'b1;
        for (int i = 0; i < 8192; i++) put((i == 100) ? 8'hFF : 8'h5A, i == 0);
        for (int i = 0; i < 4; i++) tick();
        mon_en = 1'b0;
        chk("plane_nblk", nblk, 256);
        chk("plane_npd", npd, 1);
        chk("plane_sync_err", sync_err, 0);
        for (int i = 0; i < 32; i++) put(8'h33, 1'b0);
        chk("next_valid", blk_valid, 1);
        chk("next_idx", blk_idx, 0);
        chk("next_last", blk_last, 0);
        chk("next_data", blk_data, {32{8'h33}});
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
